// File: rtl/cpu_defs_pkg.sv
// Shared fetch definitions: reset PC, fetch FSM encodings, redirect-source priority.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  typedef enum logic {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  // Higher encoding wins: exception > ertn > branch.
  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_BR   = 2'd1,
    REDIR_ERTN = 2'd2,
    REDIR_EX   = 2'd3
  } redir_src_e;

  function automatic redir_src_e redir_pick(input logic ex, input logic ertn, input logic br);
    if (ex)        return REDIR_EX;
    else if (ertn) return REDIR_ERTN;
    else if (br)   return REDIR_BR;
    else           return REDIR_NONE;
  endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_arb.sv
// Combinational priority select of the redirect sources onto one target address.
module redirect_arb
  import cpu_defs::*;
#(
  parameter int PC_W = 32
) (
  input  logic            i_ex_valid,
  input  logic [PC_W-1:0] i_ex_entry,
  input  logic            i_ertn_valid,
  input  logic [PC_W-1:0] i_ertn_era,
  input  logic            i_br_taken,
  input  logic [PC_W-1:0] i_br_target,
  output logic            o_redirect,
  output logic [PC_W-1:0] o_target
);

  redir_src_e w_src;

  always_comb begin
    w_src      = redir_pick(i_ex_valid, i_ertn_valid, i_br_taken);
    o_redirect = (w_src != REDIR_NONE);
    case (w_src)
      REDIR_EX:   o_target = i_ex_entry;
      REDIR_ERTN: o_target = i_ertn_era;
      default:    o_target = i_br_target;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Pre-IF fetch controller: owns the fetch PC, drives the 1-cycle instruction SRAM,
// arbitrates redirects. Optional perf counters under FETCH_PERF_EN.
module fetch_ctrl
  import cpu_defs::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(cpu_defs::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_allowin,
  output logic            if_validin,
  output logic [PC_W-1:0] if_pc,
  output logic            if_adef,
  output logic            if_cancel,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_entry,
  input  logic            ertn_valid,
  input  logic [PC_W-1:0] ertn_era,
  output logic            inst_sram_en,
  output logic [3:0]      inst_sram_we,
  output logic [PC_W-1:0] inst_sram_addr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_redirect_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  fetch_state_e    r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic            r_valid;
  logic [PC_W-1:0] w_target, w_nextpc, w_seqpc;
  logic            w_arb_redirect, w_redirect, w_advance, w_en;

  redirect_arb #(.PC_W(PC_W)) u_arb (
    .i_ex_valid   (ex_valid),
    .i_ex_entry   (ex_entry),
    .i_ertn_valid (ertn_valid),
    .i_ertn_era   (ertn_era),
    .i_br_taken   (br_taken),
    .i_br_target  (br_target),
    .o_redirect   (w_arb_redirect),
    .o_target     (w_target)
  );

  // Redirects only count in RUN; in BOOT the later stages are still empty.
  assign w_redirect = !rst && (r_state == FETCH_RUN) && w_arb_redirect;
  assign w_advance  = !r_valid || if_allowin;
  assign w_seqpc    = r_pc + PC_W'(4);

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH_BOOT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == FETCH_BOOT) w_state_nxt = FETCH_RUN;
  end

  always_comb begin
    w_nextpc   = RESET_PC;
    w_en       = 1'b0;
    if_validin = 1'b0;
    if_cancel  = 1'b0;
    if (!rst) begin
      case (r_state)
        FETCH_BOOT: w_en = 1'b1;
        FETCH_RUN: begin
          w_nextpc   = w_redirect ? w_target : w_seqpc;
          w_en       = w_advance || w_redirect;
          if_validin = r_valid && !w_redirect;
          if_cancel  = w_redirect;
        end
        default: ;
      endcase
    end
  end

  // Holding pc/valid when not enabled keeps the SRAM output stable across IF stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC - PC_W'(4);
      r_valid <= 1'b0;
    end else if (w_en) begin
      r_pc    <= w_nextpc;
      r_valid <= 1'b1;
    end
  end

  assign if_pc          = r_pc;
  assign if_adef        = |r_pc[1:0];
  assign inst_sram_en   = w_en;
  assign inst_sram_we   = 4'b0;
  assign inst_sram_addr = w_nextpc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt, r_redirect_cnt, r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt    <= '0;
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (if_validin && if_allowin)              r_fetch_cnt    <= r_fetch_cnt + 32'd1;
      if (w_redirect)                            r_redirect_cnt <= r_redirect_cnt + 32'd1;
      if (r_valid && !if_allowin && !w_redirect) r_stall_cnt    <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt    = r_fetch_cnt;
  assign perf_redirect_cnt = r_redirect_cnt;
  assign perf_stall_cnt    = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_fetch_ctrl;

  logic        clk, rst, if_allowin;
  logic        br_taken, ex_valid, ertn_valid;
  logic [31:0] br_target, ex_entry, ertn_era;
  logic        if_validin, if_adef, if_cancel, inst_sram_en;
  logic [31:0] if_pc, inst_sram_addr;
  logic [3:0]  inst_sram_we;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_redirect_cnt, perf_stall_cnt;
`endif

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .if_allowin     (if_allowin),
    .if_validin     (if_validin),
    .if_pc          (if_pc),
    .if_adef        (if_adef),
    .if_cancel      (if_cancel),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .ex_valid       (ex_valid),
    .ex_entry       (ex_entry),
    .ertn_valid     (ertn_valid),
    .ertn_era       (ertn_era),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_redirect_cnt (perf_redirect_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        cn;
    logic        ad;
    bit          perf0;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
    end
  endtask

  // Drives one cycle of inputs and queues what the DUT should show during that cycle.
  task automatic step(input string nm, input logic r, input logic a,
                      input logic b, input logic [31:0] bt,
                      input logic e, input logic [31:0] et,
                      input logic er, input logic [31:0] ea,
                      input logic x_en, input logic [31:0] x_addr, input logic x_vld,
                      input logic [31:0] x_pc, input logic x_cn, input logic x_ad,
                      input bit perf0);
    exp_t x;
    #1;
    rst = r; if_allowin = a;
    br_taken = b; br_target = bt;
    ex_valid = e; ex_entry = et;
    ertn_valid = er; ertn_era = ea;
    x.nm = nm; x.en = x_en; x.addr = x_addr; x.vld = x_vld;
    x.pc = x_pc; x.cn = x_cn; x.ad = x_ad; x.perf0 = perf0;
    sbq.push_back(x);
    @(posedge clk);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk(e.nm, "en",     {31'b0, inst_sram_en}, {31'b0, e.en});
      chk(e.nm, "addr",   inst_sram_addr,        e.addr);
      chk(e.nm, "validin",{31'b0, if_validin},   {31'b0, e.vld});
      chk(e.nm, "pc",     if_pc,                 e.pc);
      chk(e.nm, "cancel", {31'b0, if_cancel},    {31'b0, e.cn});
      chk(e.nm, "adef",   {31'b0, if_adef},      {31'b0, e.ad});
      chk(e.nm, "we",     {28'b0, inst_sram_we}, 32'h0);
`ifdef FETCH_PERF_EN
      if (e.perf0) begin
        chk(e.nm, "perf_fetch",    perf_fetch_cnt,    32'h0);
        chk(e.nm, "perf_redirect", perf_redirect_cnt, 32'h0);
        chk(e.nm, "perf_stall",    perf_stall_cnt,    32'h0);
      end
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_allowin = 1'b0;
    br_taken = 1'b0; br_target = '0;
    ex_valid = 1'b0; ex_entry = '0;
    ertn_valid = 1'b0; ertn_era = '0;
    @(posedge clk);
    //   name           rst al br target        ex entry          er era            en addr          vld pc            cn ad perf0
    step("rst",         1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h1C000000, 0, 32'h1BFFFFFC, 0, 0, 1);
    step("boot",        0, 1, 1, 32'h1C000900, 1, 32'h1C000A00, 0, 32'h0,         1, 32'h1C000000, 0, 32'h1BFFFFFC, 0, 0, 0);
    step("seq0",        0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h1C000004, 1, 32'h1C000000, 0, 0, 0);
    step("seq1",        0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h1C000008, 1, 32'h1C000004, 0, 0, 0);
    step("stall0",      0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h1C00000C, 1, 32'h1C000008, 0, 0, 0);
    step("stall1",      0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h1C00000C, 1, 32'h1C000008, 0, 0, 0);
    step("stall2",      0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h1C00000C, 1, 32'h1C000008, 0, 0, 0);
    step("release",     0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h1C00000C, 1, 32'h1C000008, 0, 0, 0);
    step("br_stall",    0, 0, 1, 32'h1C000100, 0, 32'h0,         0, 32'h0,         1, 32'h1C000100, 0, 32'h1C00000C, 1, 0, 0);
    step("br_land",     0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h1C000104, 1, 32'h1C000100, 0, 0, 0);
    step("prio3",       0, 1, 1, 32'h1C000200, 1, 32'h1C008000, 1, 32'h1C000040, 1, 32'h1C008000, 0, 32'h1C000104, 1, 0, 0);
    step("prio2",       0, 1, 1, 32'h1C000200, 0, 32'h0,         1, 32'h1C000040, 1, 32'h1C000040, 0, 32'h1C008000, 1, 0, 0);
    step("prio_land",   0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h1C000044, 1, 32'h1C000040, 0, 0, 0);
    step("wrap_br",     0, 1, 1, 32'hFFFFFFFC, 0, 32'h0,         0, 32'h0,         1, 32'hFFFFFFFC, 0, 32'h1C000044, 1, 0, 0);
    step("wrap",        0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h00000000, 1, 32'hFFFFFFFC, 0, 0, 0);
    step("wrap_next",   0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h00000004, 1, 32'h00000000, 0, 0, 0);
    step("adef_br",     0, 1, 1, 32'h1C000102, 0, 32'h0,         0, 32'h0,         1, 32'h1C000102, 0, 32'h00000004, 1, 0, 0);
    step("adef",        0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h1C000106, 1, 32'h1C000102, 0, 1, 0);
    step("rst_mid",     1, 0, 1, 32'h1C000300, 1, 32'h1C000400, 0, 32'h0,         0, 32'h1C000000, 0, 32'h1C000102, 0, 1, 0);
    step("rst2",        1, 0, 1, 32'h1C000300, 0, 32'h0,         0, 32'h0,         0, 32'h1C000000, 0, 32'h1BFFFFFC, 0, 0, 1);
    step("boot2",       0, 0, 1, 32'h1C000300, 0, 32'h0,         0, 32'h0,         1, 32'h1C000000, 0, 32'h1BFFFFFC, 0, 0, 0);
    step("boot2_run",   0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h1C000004, 1, 32'h1C000000, 0, 0, 0);
    repeat (2) @(posedge clk);
    chk("drain", "pending", sbq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Pre-IF fetch controller for the 5-stage in-order CPU.
- Owns the fetch PC and computes next-PC.
- Drives the synchronous instruction SRAM, which returns read data one cycle after a request.
- Feeds the IF stage's validin/input_pc handshake and arbitrates redirect sources (exception entry, ertn, branch) onto the single SRAM read port, emitting cancel to IF on every redirect.

Parameters:
- RESET_PC, 32'h1C000000, first fetch address after reset.
- PC_W, 32, PC and SRAM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_allowin  in  1  IF stage can accept this cycle.
- if_validin  out  1  fetch result valid toward IF.
- if_pc  out  PC_W  PC of the instruction currently on inst_sram_rdata.
- if_adef  out  1  if_pc[1:0] != 0 (misaligned fetch flag, travels with the instruction).
- if_cancel  out  1  kill the instruction held in IF's register.
- br_taken  in  1  branch/jump redirect request from EX.
- br_target  in  PC_W  branch target.
- ex_valid  in  1  exception redirect from WB.
- ex_entry  in  PC_W  exception entry address.
- ertn_valid  in  1  ertn redirect from WB.
- ertn_era  in  PC_W  return address.
- inst_sram_en  out  1  read request this cycle.
- inst_sram_we  out  4  tied 4'b0.
- inst_sram_addr  out  PC_W  request address (= nextpc).

Behaviour:
- State: pc_q (PC_W), valid_q (1), FSM {BOOT, RUN}.
- Reset, synchronous, with priority over everything:
  - pc_q = RESET_PC-4, valid_q = 0, state = BOOT.
  - During reset: inst_sram_en = 0, if_validin = 0, if_cancel = 0, inst_sram_addr = RESET_PC.
- BOOT, the first cycle after rst deasserts:
  - nextpc = RESET_PC, inst_sram_en = 1.
  - pc_q <= RESET_PC, valid_q <= 1, go to RUN.
  - Redirect inputs are ignored, because later stages are empty.
  - if_validin = 0.
- RUN:
  - Redirect priority: ex_valid > ertn_valid > br_taken.
  - redirect = OR of all three; target = the winning address.
  - advance = !valid_q || if_allowin.
  - nextpc = redirect ? target : pc_q + 4. The add wraps modulo 2^PC_W, so 32'hFFFFFFFC -> 0.
  - inst_sram_en = advance || redirect; inst_sram_addr = nextpc, driven combinationally.
  - On inst_sram_en: pc_q <= nextpc, valid_q <= 1.
  - When inst_sram_en = 0: pc_q and valid_q hold. The SRAM is not re-addressed, so rdata stays stable while IF stalls.
- Outputs:
  - if_validin = valid_q && !redirect && state == RUN. A same-cycle redirect kills the fetch on rdata.
  - if_cancel = redirect, for exactly one cycle per redirect cycle.
  - if_pc = pc_q.
  - if_adef = |pc_q[1:0].
- Redirect while IF stalled (if_allowin = 0):
  - The target is still issued at once.
  - The stale buffered fetch is dropped, never delivered.
- Redirect latency: target appears at if_pc with if_validin = 1 on the cycle after the redirect cycle, unless another redirect arrives in that cycle.
- Back-to-back redirects: each cycle's winner is issued. Only the last one is delivered.
- Reset asserted mid-stall or mid-redirect: all state is discarded and BOOT is re-entered.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds output ports:
  - perf_fetch_cnt (32): count of cycles with if_validin && if_allowin.
  - perf_redirect_cnt (32): count of cycles with redirect.
  - perf_stall_cnt (32): count of cycles with valid_q && !if_allowin && !redirect.
- Counter rules: reset to 0, wrap at 2^32, saturate never.
- When undefined: the ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Shared package/header `cpu_defs`:
  - RESET_PC constant.
  - FSM state encodings FETCH_BOOT = 1'b0, FETCH_RUN = 1'b1.
  - Redirect-source priority encoding.
- One natural sub-module: redirect_arb (combinational priority select producing redirect and target). The rest lives in fetch_ctrl.

Test Plan:
- Reset release, if_allowin = 1:
  - BOOT cycle: addr 0x1C000000.
  - Then if_pc sequence 0x1C000000, 0x1C000004, 0x1C000008, with if_validin = 1 every cycle from the cycle after BOOT.
- Hold if_allowin = 0 for 3 cycles at if_pc = 0x1C000008:
  - inst_sram_en = 0 and if_pc stable for all 3 cycles.
  - On release, addr 0x1C00000C.
- br_taken = 1 to 0x1C000100 during a stall:
  - Same cycle: if_cancel = 1, if_validin = 0, en = 1, addr 0x1C000100.
  - Next cycle: if_pc = 0x1C000100, valid = 1.
- Simultaneous ex_valid (0x1C008000), ertn_valid (0x1C000040) and br_taken (0x1C000200) -> addr 0x1C008000; ertn_valid + br_taken only -> addr 0x1C000040.
- Edge addresses:
  - br_target = 0xFFFFFFFC -> next sequential addr 0x00000000.
  - br_target = 0x1C000102 -> if_adef = 1.
- rst asserted during a stall with a redirect pending -> en = 0, if_validin = 0 during reset, then the BOOT fetch of 0x1C000000. With FETCH_PERF_EN, all counters read 0.
